// File: rtl/key_tone_gen.sv
// Key-to-buzzer tone generator: synchronised, debounced keys select a
// square-wave tone, played continuously or as a fixed-length one-shot beep.
module key_tone_gen #(
  parameter int N_KEYS      = 5,
  parameter int CNT_W       = 32,
  parameter int DEB_CYCLES  = 1_000_000,
  parameter int BASE_HALF   = 100_000,
  parameter int HOLD_CYCLES = 25_000_000,
  parameter int IDX_W       = $clog2(N_KEYS+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  input  logic              mode,
  output logic              beep,
  output logic [N_KEYS-1:0] led,
  output logic              busy,
  output logic [IDX_W-1:0]  tone_idx
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PLAY     = 2'd1;
  localparam logic [1:0] WAIT_REL = 2'd2;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [N_KEYS-1:0] key_s1;
  logic [N_KEYS-1:0] key_s2;
  logic [N_KEYS-1:0] stable;
  logic [CNT_W-1:0]  deb_cnt [N_KEYS];

  logic              mode_s1;
  logic              mode_s2;
  logic              mode_q;
  logic              mode_chg;

  logic [IDX_W-1:0]  req_nxt;
  logic [IDX_W-1:0]  req_idx;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [CNT_W-1:0]  dur;
  logic [CNT_W-1:0]  dur_nxt;
  logic [IDX_W-1:0]  tone_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  half;
  logic [CNT_W-1:0]  half_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1  <= '1;
      key_s2  <= '1;
      mode_s1 <= 1'b0;
      mode_s2 <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      key_s1  <= key;
      key_s2  <= key_s1;
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
      mode_q  <= mode_s2;
    end
  end

  assign mode_chg = mode_s2 ^ mode_q;

  // stable only moves after DEB_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '1;
      for (int i = 0; i < N_KEYS; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (key_s2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= key_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + ONE;
        end
      end
    end
  end

  assign led = stable;

  always_comb begin
    req_nxt = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (!stable[i]) begin
        req_nxt = IDX_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_idx <= '0;
    end else begin
      req_idx <= req_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dur_nxt   = dur;
    tone_nxt  = tone_idx;
    if (mode_chg) begin
      state_nxt = IDLE;
      dur_nxt   = '0;
      tone_nxt  = '0;
    end else if (!mode_s2) begin
      state_nxt = IDLE;
      dur_nxt   = '0;
      tone_nxt  = req_idx;
    end else begin
      unique case (1'b1)
        (state == PLAY): begin
          if (dur == HOLD_LAST) begin
            tone_nxt  = '0;
            dur_nxt   = '0;
            state_nxt = WAIT_REL;
          end else begin
            dur_nxt = dur + ONE;
          end
        end
        (state == WAIT_REL): begin
          tone_nxt = '0;
          if (req_idx == '0) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          tone_nxt = '0;
          dur_nxt  = '0;
          if (req_idx != '0) begin
            tone_nxt  = req_idx;
            state_nxt = PLAY;
          end
        end
      endcase
    end
  end

  assign half      = CNT_W'(BASE_HALF) * CNT_W'(tone_idx);
  assign half_last = half - ONE;

  // a tone change restarts the divider so the new pitch begins at phase 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dur      <= '0;
      tone_idx <= '0;
      cnt      <= '0;
      beep     <= 1'b0;
    end else begin
      state    <= state_nxt;
      dur      <= dur_nxt;
      tone_idx <= tone_nxt;
      if (tone_nxt != tone_idx || tone_nxt == '0) begin
        cnt  <= '0;
        beep <= 1'b0;
      end else if (cnt == half_last) begin
        cnt  <= '0;
        beep <= ~beep;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  assign busy = (tone_idx != '0);

endmodule

// File: tb/tb_key_tone_gen.sv
// Directed bench for key_tone_gen with short debounce and tone constants.
module tb_key_tone_gen;

  localparam int N_KEYS = 5;
  localparam int IDX_W  = 3;

  logic              clk;
  logic              rst_n;
  logic [N_KEYS-1:0] key;
  logic              mode;
  logic              beep;
  logic [N_KEYS-1:0] led;
  logic              busy;
  logic [IDX_W-1:0]  tone_idx;

  int n_vec;
  int n_bad;

  key_tone_gen #(
    .N_KEYS     (N_KEYS),
    .CNT_W      (32),
    .DEB_CYCLES (4),
    .BASE_HALF  (3),
    .HOLD_CYCLES(20),
    .IDX_W      (IDX_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (key),
    .mode    (mode),
    .beep    (beep),
    .led     (led),
    .busy    (busy),
    .tone_idx(tone_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic [31:0] t,
                         input logic [31:0] b,
                         input logic [31:0] bz);
    chk({tag, "_tone"}, 32'(tone_idx), t);
    chk({tag, "_beep"}, 32'(beep), b);
    chk({tag, "_busy"}, 32'(busy), bz);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    key   = 5'b11111;
    mode  = 1'b0;

    step(3);
    chk_out("rst", 32'd0, 32'd0, 32'd0);
    chk("rst_led", 32'(led), 32'h1f);
    rst_n = 1'b1;
    step(2);

    // 3-cycle glitch on key0 must be filtered
    key = 5'b11110;
    step(3);
    key = 5'b11111;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("glitch_led", 32'(led), 32'h1f);
      chk("glitch_tone", 32'(tone_idx), 32'd0);
    end

    // held key0: led changes exactly 6 cycles after the edge
    key = 5'b11110;
    step(5);
    chk("deb_early", 32'(led), 32'h1f);
    step(1);
    chk("deb_6cyc", 32'(led), 32'h1e);
    step(2);
    chk("deb_tone", 32'(tone_idx), 32'd1);
    key = 5'b11111;
    step(10);
    chk_out("deb_rel", 32'd0, 32'd0, 32'd0);

    // continuous key1: half period 6
    key = 5'b11101;
    step(8);
    chk_out("cont_start", 32'd2, 32'd0, 32'd1);
    step(5);
    chk("cont_b5", 32'(beep), 32'd0);
    step(1);
    chk("cont_b6", 32'(beep), 32'd1);
    step(5);
    chk("cont_b11", 32'(beep), 32'd1);
    step(1);
    chk("cont_b12", 32'(beep), 32'd0);
    key = 5'b11111;
    step(7);
    chk("cont_rel_busy", 32'(busy), 32'd1);
    step(1);
    chk_out("cont_rel", 32'd0, 32'd0, 32'd0);

    // priority and re-phase: key2 then key0 added
    key = 5'b11011;
    step(8);
    chk("pri_t3", 32'(tone_idx), 32'd3);
    step(8);
    chk("pri_b8", 32'(beep), 32'd0);
    step(1);
    chk("pri_b9", 32'(beep), 32'd1);
    key = 5'b11010;
    step(7);
    chk("pri_hold3", 32'(tone_idx), 32'd3);
    step(1);
    chk_out("pri_chg", 32'd1, 32'd0, 32'd1);
    chk("pri_cnt", dut.cnt, 32'd0);
    step(2);
    chk("pri_b2", 32'(beep), 32'd0);
    step(1);
    chk("pri_b3", 32'(beep), 32'd1);
    step(3);
    chk("pri_b6", 32'(beep), 32'd0);
    key = 5'b11111;
    step(10);
    chk("pri_rel", 32'(tone_idx), 32'd0);

    // one-shot: key4 held 100 cycles gives one 20-cycle beep
    mode = 1'b1;
    step(4);
    key = 5'b01111;
    step(7);
    chk("os_pre", 32'(tone_idx), 32'd0);
    step(1);
    chk_out("os_start", 32'd5, 32'd0, 32'd1);
    step(15);
    chk("os_b15", 32'(beep), 32'd1);
    step(4);
    chk("os_last", 32'(tone_idx), 32'd5);
    step(1);
    chk_out("os_end", 32'd0, 32'd0, 32'd0);
    step(72);
    chk_out("os_held", 32'd0, 32'd0, 32'd0);
    key = 5'b11111;
    step(10);
    key = 5'b01111;
    step(8);
    chk("os2_start", 32'(tone_idx), 32'd5);
    step(19);
    chk("os2_last", 32'(tone_idx), 32'd5);
    step(1);
    chk_out("os2_end", 32'd0, 32'd0, 32'd0);
    key = 5'b11111;
    step(10);

    // mode flip 1->0 mid-beep on key3
    key = 5'b10111;
    step(13);
    chk("ms_play", 32'(tone_idx), 32'd4);
    mode = 1'b0;
    step(2);
    chk("ms_sync", 32'(tone_idx), 32'd4);
    step(1);
    chk_out("ms_idle", 32'd0, 32'd0, 32'd0);
    step(1);
    chk_out("ms_cont", 32'd4, 32'd0, 32'd1);
    step(11);
    chk("ms_b11", 32'(beep), 32'd0);
    step(1);
    chk("ms_b12", 32'(beep), 32'd1);

    // async reset while beep is high
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 32'd0, 32'd0, 32'd0);
    chk("arst_led", 32'(led), 32'h1f);
    step(1);
    rst_n = 1'b1;
    step(2);
    chk("arst_rel_led", 32'(led), 32'h1f);
    chk("arst_rel_tone", 32'(tone_idx), 32'd0);
    step(4);
    chk("arst_deb_led", 32'(led), 32'h17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/key_tone_gen.md
Name: key_tone_gen

Overview:
- Parametrised successor of the board's key-to-buzzer demo.
- Takes N_KEYS raw active-low push keys and synchronises and debounces each one.
- Priority-encodes the debounced keys into a tone index and drives a square wave on the buzzer pin. The half-period is a multiple of BASE_HALF.
- Adds silence when no key is pressed, plus a one-shot mode with a fixed beep duration and release re-arm. Sits directly between the board key pins, LEDs and buzzer.

Parameters:
- N_KEYS, 5, number of key inputs / LEDs.
- CNT_W, 32, width of the divider and duration counters.
- DEB_CYCLES, 1_000_000, consecutive stable cycles required to accept a key change (20 ms at 50 MHz).
- BASE_HALF, 100_000, buzzer half-period in clk cycles for tone index 1.
- HOLD_CYCLES, 25_000_000, one-shot beep length in clk cycles.
- IDX_W, $clog2(N_KEYS+1), width of tone_idx.

Ports:
- clk, input, 1, system clock, single clock domain.
- rst_n, input, 1, asynchronous active-low reset.
- key, input, N_KEYS, raw keys, active-low (0 = pressed), asynchronous to clk.
- mode, input, 1, 0 = continuous (tone while held), 1 = one-shot (fixed duration per press).
- beep, output, 1, buzzer square wave.
- led, output, N_KEYS, debounced key vector, same polarity as key.
- busy, output, 1, high while the tone generator is toggling.
- tone_idx, output, IDX_W, active tone index: 0 = none, i+1 = key i.

Behaviour:
- Reset (async assert, sync release):
  - Debounced state all 1s (released).
  - led all 1s, beep = 0, busy = 0, tone_idx = 0.
  - Divider and duration counters = 0; FSM = IDLE.
- Synchronisation: each key bit passes through two flops before debounce.
- Debounce, per bit:
  - The counter increments while the synced value differs from the stable value, and clears when they match.
  - When the counter reaches DEB_CYCLES-1, stable takes the synced value and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles never reach stable.
- led is registered and equals stable. Latency from a raw edge to led is 2 + DEB_CYCLES cycles.
- Priority: req_idx = 1 + lowest i with stable[i] = 0, or 0 if none. Registered, so it lags stable by 1 cycle.
- Half-period: half = BASE_HALF * tone_idx, computed at CNT_W width. Overflow of that product is a parameter error and is not handled at runtime.
- Divider:
  - When tone_idx = 0: cnt = 0, beep = 0, busy = 0.
  - Otherwise busy = 1 and cnt increments each cycle. On cnt == half-1, cnt resets to 0 and beep toggles.
  - When tone_idx changes to any new value: cnt resets to 0 and beep to 0 in the same cycle, so the new tone starts from a clean phase.
- Continuous mode (mode = 0): tone_idx follows req_idx every cycle. There is no default tone; silence when released.
- One-shot mode (mode = 1), FSM with three states:
  - IDLE: tone_idx = 0. When req_idx != 0: latch req_idx into tone_idx, clear dur, go to PLAY.
  - PLAY: tone_idx holds the latched value, and later presses are ignored. dur increments each cycle. On dur == HOLD_CYCLES-1, set tone_idx = 0 and go to WAIT_REL.
  - WAIT_REL: tone_idx = 0. When req_idx == 0, go to IDLE. Holding a key therefore yields exactly one beep.
- Mode change: mode passes through two sync flops. Any change of the synced mode forces FSM = IDLE, tone_idx = 0, beep = 0 and cnt = 0 on the following cycle.
- Simultaneous press and release of different keys: the result follows the priority rule on the new stable vector in the same cycle.
- Reset asserted mid-tone: beep drops to 0 immediately (async). After release the block restarts from IDLE with all keys treated as released until debounce completes.

Test Plan:
Bench parameters: DEB_CYCLES=4, BASE_HALF=3, HOLD_CYCLES=20, N_KEYS=5.
- Reset: hold rst_n=0 with key=5'b11111 -> beep=0, busy=0, tone_idx=0, led=5'b11111. Toggle rst_n mid-tone -> beep=0 in the same cycle.
- Debounce: pulse key[0]=0 for 3 cycles -> led unchanged and tone_idx stays 0. Hold key[0]=0 for 10 cycles -> led=5'b11110 exactly 6 cycles after the edge.
- Continuous tone, mode=0: hold key[1] -> tone_idx=2, half=6, beep toggles every 6 cycles. Release -> beep=0 and busy=0 once the debounced release propagates.
- Priority and re-phase, mode=0: hold key[2] (tone_idx=3, toggle every 9 cycles), then add key[0] -> tone_idx=1, with beep=0 and cnt=0 on the change cycle and toggles every 3 cycles after.
- One-shot: mode=1, hold key[4] for 100 cycles -> tone_idx=5 for exactly 20 cycles, then 0 with beep=0 until release. Release and press again -> a second 20-cycle beep.
- Mode switch mid-PLAY: flip mode 1->0 during a one-shot -> beep=0 and FSM=IDLE, then the continuous tone of the held key resumes.
